arith_checker: RTL and testbench



---
 rtl/arith_checker_if.sv | 39 +++
 rtl/arith_checker.sv | 164 ++++++++++++++++
 tb/tb_arith_checker.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/arith_checker_if.sv
`default_nettype none
// ============================================================================
//  Module   : arith_checker_if
//  Purpose  : Control, stimulus and result bundle between arith_checker and
//             its environment (the DUT under test and the supervising logic).
//  Revision : 1.0
// ============================================================================
interface arith_checker_if #(
    parameter int WIDTH     = 32,
    parameter int CTR_WIDTH = 32
);
    logic                 enable;
    logic                 freeze;
    logic                 i_stop_on_err;
    logic [1:0]           i_mode;
    logic [WIDTH-1:0]     o_drive_a;
    logic [WIDTH-1:0]     o_drive_b;
    logic [WIDTH-1:0]     i_dut_out;
    logic [CTR_WIDTH-1:0] o_data_ctr;
    logic [CTR_WIDTH-1:0] o_event_ctr;
    logic                 o_err_valid;
    logic [WIDTH-1:0]     o_err_a;
    logic [WIDTH-1:0]     o_err_b;
    logic [WIDTH-1:0]     o_err_got;
    logic [1:0]           o_state;

    modport master (
        input  enable, freeze, i_stop_on_err, i_mode, i_dut_out,
        output o_drive_a, o_drive_b, o_data_ctr, o_event_ctr,
               o_err_valid, o_err_a, o_err_b, o_err_got, o_state
    );

    modport slave (
        output enable, freeze, i_stop_on_err, i_mode, i_dut_out,
        input  o_drive_a, o_drive_b, o_data_ctr, o_event_ctr,
               o_err_valid, o_err_a, o_err_b, o_err_got, o_state
    );
endinterface
`default_nettype wire

// File: rtl/arith_checker.sv
`default_nettype none
// ============================================================================
//  Module   : arith_checker
//  Purpose  : LFSR stimulus generator plus latency-matched reference checker
//             for a two-operand arithmetic DUT, with counters and capture.
//  Revision : 1.0
// ============================================================================
module arith_checker #(
    parameter int          WIDTH     = 32,
    parameter int          LATENCY   = 1,
    parameter int          CTR_WIDTH = 32,
    parameter logic [63:0] TAPS      = 64'h0000_0000_8020_0003,
    parameter logic [63:0] SEED_A    = 64'h0000_0000_CAFE_F00D,
    parameter logic [63:0] SEED_B    = 64'h0000_0000_FEED_C0DE
) (
    input  logic            clk_dut,
    input  logic            reset,
    arith_checker_if.master bus
);

    localparam logic [WIDTH-1:0] C_TAPS   = TAPS[WIDTH-1:0];
    localparam logic [WIDTH-1:0] C_ONE    = WIDTH'(1);
    // An all-zero seed would lock the LFSR, so it is replaced by 1.
    localparam logic [WIDTH-1:0] C_SEED_A = (SEED_A[WIDTH-1:0] == '0) ? C_ONE : SEED_A[WIDTH-1:0];
    localparam logic [WIDTH-1:0] C_SEED_B = (SEED_B[WIDTH-1:0] == '0) ? C_ONE : SEED_B[WIDTH-1:0];

    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_RUN    = 2'b01,
        S_FROZEN = 2'b10,
        S_HALTED = 2'b11
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [WIDTH-1:0]     r_lfsr_a;
    logic [WIDTH-1:0]     r_lfsr_b;
    logic [WIDTH-1:0]     w_next_a;
    logic [WIDTH-1:0]     w_next_b;
    logic                 r_dl_valid [LATENCY];
    logic [WIDTH-1:0]     r_dl_a     [LATENCY];
    logic [WIDTH-1:0]     r_dl_b     [LATENCY];
    logic [1:0]           r_dl_mode  [LATENCY];
    logic [CTR_WIDTH-1:0] r_data_ctr;
    logic [CTR_WIDTH-1:0] r_event_ctr;
    logic                 r_err_valid;
    logic [WIDTH-1:0]     r_err_a;
    logic [WIDTH-1:0]     r_err_b;
    logic [WIDTH-1:0]     r_err_got;
    logic                 w_issue;
    logic                 w_counted;
    logic                 w_count_err;
    logic [WIDTH-1:0]     w_expected;

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? C_TAPS : '0);
    endfunction

    function automatic logic [WIDTH-1:0] apply_op(input logic [1:0] m,
                                                  input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (m)
            2'b00:   return a + b;
            2'b01:   return a - b;
            2'b10:   return a ^ b;
            default: return a & b;
        endcase
    endfunction

    // Frozen/halted states and a freeze on this very edge discard the compare.
    always_comb begin
        w_expected  = apply_op(r_dl_mode[LATENCY-1], r_dl_a[LATENCY-1], r_dl_b[LATENCY-1]);
        w_counted   = r_dl_valid[LATENCY-1] && !bus.freeze &&
                      ((r_state == S_RUN) || (r_state == S_IDLE));
        w_count_err = w_counted && (w_expected != bus.i_dut_out);
        w_next_a    = lfsr_step(r_lfsr_a);
        w_next_b    = lfsr_step(r_lfsr_b);
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (bus.enable && !bus.freeze) w_next_state = S_RUN;
            S_RUN: begin
                if (bus.freeze)                                w_next_state = S_FROZEN;
                else if (w_count_err && bus.i_stop_on_err)     w_next_state = S_HALTED;
                else if (!bus.enable)                          w_next_state = S_IDLE;
            end
            S_FROZEN: if (!bus.freeze) w_next_state = bus.enable ? S_RUN : S_IDLE;
            default:  w_next_state = S_HALTED;
        endcase
        w_issue = (w_next_state == S_RUN);
    end

    always_ff @(posedge clk_dut or posedge reset) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_lfsr_a <= C_SEED_A;
            r_lfsr_b <= C_SEED_B;
        end else begin
            r_state <= w_next_state;
            if (w_issue) begin
                r_lfsr_a <= w_next_a;
                r_lfsr_b <= w_next_b;
            end
        end
    end

    always_ff @(posedge clk_dut or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < LATENCY; i++) begin
                r_dl_valid[i] <= 1'b0;
                r_dl_a[i]     <= '0;
                r_dl_b[i]     <= '0;
                r_dl_mode[i]  <= 2'b00;
            end
        end else begin
            r_dl_valid[0] <= w_issue;
            r_dl_a[0]     <= w_next_a;
            r_dl_b[0]     <= w_next_b;
            r_dl_mode[0]  <= bus.i_mode;
            for (int i = 1; i < LATENCY; i++) begin
                r_dl_valid[i] <= r_dl_valid[i-1];
                r_dl_a[i]     <= r_dl_a[i-1];
                r_dl_b[i]     <= r_dl_b[i-1];
                r_dl_mode[i]  <= r_dl_mode[i-1];
            end
        end
    end

    always_ff @(posedge clk_dut or posedge reset) begin
        if (reset) begin
            r_data_ctr  <= '0;
            r_event_ctr <= '0;
            r_err_valid <= 1'b0;
            r_err_a     <= '0;
            r_err_b     <= '0;
            r_err_got   <= '0;
        end else begin
            if (w_counted && (r_data_ctr != '1))
                r_data_ctr <= r_data_ctr + CTR_WIDTH'(1);
            if (w_count_err && (r_event_ctr != '1))
                r_event_ctr <= r_event_ctr + CTR_WIDTH'(1);
            if (w_count_err && !r_err_valid) begin
                r_err_valid <= 1'b1;
                r_err_a     <= r_dl_a[LATENCY-1];
                r_err_b     <= r_dl_b[LATENCY-1];
                r_err_got   <= bus.i_dut_out;
            end
        end
    end

    assign bus.o_drive_a   = r_lfsr_a;
    assign bus.o_drive_b   = r_lfsr_b;
    assign bus.o_data_ctr  = r_data_ctr;
    assign bus.o_event_ctr = r_event_ctr;
    assign bus.o_err_valid = r_err_valid;
    assign bus.o_err_a     = r_err_a;
    assign bus.o_err_b     = r_err_b;
    assign bus.o_err_got   = r_err_got;
    assign bus.o_state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_arith_checker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_arith_checker
//  Purpose  : Self-checking bench for arith_checker with three configurations
//             and behavioural DUT stand-ins (correct, faulty, mis-timed).
//  Revision : 1.0
// ============================================================================
module tb_arith_checker;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    arith_checker_if #(.WIDTH(32), .CTR_WIDTH(32)) ifa ();
    arith_checker_if #(.WIDTH(16), .CTR_WIDTH(16)) ifb ();
    arith_checker_if #(.WIDTH(8),  .CTR_WIDTH(4))  ifc ();

    arith_checker #(.WIDTH(32), .LATENCY(1), .CTR_WIDTH(32)) u_a (
        .clk_dut(clk), .reset(reset), .bus(ifa));
    arith_checker #(.WIDTH(16), .LATENCY(4), .CTR_WIDTH(16), .TAPS(64'hB400)) u_b (
        .clk_dut(clk), .reset(reset), .bus(ifb));
    arith_checker #(.WIDTH(8), .LATENCY(2), .CTR_WIDTH(4), .TAPS(64'hB8)) u_c (
        .clk_dut(clk), .reset(reset), .bus(ifc));

    // Reference rules, written straight from the definition of the stream and ops.
    function automatic logic [63:0] ref_step(input logic [63:0] s, input logic [63:0] taps, input int w);
        logic [63:0] mask;
        logic [63:0] v;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        v    = s & mask;
        return (v & 64'd1) != 0 ? ((v >> 1) ^ (taps & mask)) : (v >> 1);
    endfunction

    function automatic logic [63:0] ref_op(input logic [1:0] m, input logic [63:0] a,
                                           input logic [63:0] b, input int w);
        logic [63:0] mask;
        logic [63:0] r;
        mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        case (m)
            2'd0:    r = a + b;
            2'd1:    r = a - b;
            2'd2:    r = a ^ b;
            default: r = a & b;
        endcase
        return r & mask;
    endfunction

    // DUT stand-ins
    logic fault_a = 1'b0;
    assign ifa.i_dut_out = (fault_a && ifa.o_drive_a[0] && ifa.o_drive_b[0]) ?
                           ifa.o_drive_a : ifa.o_drive_a + ifa.o_drive_b;

    logic        short_b = 1'b0;
    logic [1:0]  mq_b;
    logic [15:0] pb0, pb1, pb2;
    always_ff @(posedge clk) begin
        mq_b <= ifb.i_mode;
        pb0  <= 16'(ref_op(mq_b, {48'd0, ifb.o_drive_a}, {48'd0, ifb.o_drive_b}, 16));
        pb1  <= pb0;
        pb2  <= pb1;
    end
    assign ifb.i_dut_out = short_b ? pb1 : pb2;

    logic [7:0] pc;
    always_ff @(posedge clk) pc <= ~(ifc.o_drive_a + ifc.o_drive_b);
    assign ifc.i_dut_out = pc;

    task automatic do_reset();
        ifa.enable = 0; ifb.enable = 0; ifc.enable = 0;
        ifa.freeze = 0; ifb.freeze = 0; ifc.freeze = 0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (ifa.o_drive_a !== 32'hCAFEF00D) begin n_err++; $display("FAIL rst_drive_a got %h exp %h", ifa.o_drive_a, 32'hCAFEF00D); end
        n_cmp++; if (ifa.o_drive_b !== 32'hFEEDC0DE) begin n_err++; $display("FAIL rst_drive_b got %h exp %h", ifa.o_drive_b, 32'hFEEDC0DE); end
        n_cmp++; if (ifa.o_data_ctr !== 32'd0 || ifa.o_event_ctr !== 32'd0) begin n_err++; $display("FAIL rst_ctrs got %0d/%0d exp 0/0", ifa.o_data_ctr, ifa.o_event_ctr); end
        n_cmp++; if ({ifa.o_err_valid, ifa.o_err_a, ifa.o_err_b, ifa.o_err_got} !== 97'd0) begin n_err++; $display("FAIL rst_err got v=%b a=%h b=%h g=%h exp all 0", ifa.o_err_valid, ifa.o_err_a, ifa.o_err_b, ifa.o_err_got); end
        n_cmp++; if (ifa.o_state !== 2'b00) begin n_err++; $display("FAIL rst_state got %b exp 00", ifa.o_state); end
        n_cmp++; if (ifb.o_drive_a !== 16'hF00D || ifb.o_drive_b !== 16'hC0DE) begin n_err++; $display("FAIL rst_drive_b16 got %h/%h exp f00d/c0de", ifb.o_drive_a, ifb.o_drive_b); end
        n_cmp++; if (ifc.o_drive_a !== 8'h0D || ifc.o_drive_b !== 8'hDE) begin n_err++; $display("FAIL rst_drive_c8 got %h/%h exp 0d/de", ifc.o_drive_a, ifc.o_drive_b); end
    endtask

    task automatic test_clean_run();
        logic [63:0] ea = 64'hCAFEF00D, eb = 64'hFEEDC0DE;
        do_reset();
        fault_a = 0; ifa.i_mode = 2'd0;
        ifa.enable = 1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            ea = ref_step(ea, 64'h80200003, 32);
            eb = ref_step(eb, 64'h80200003, 32);
            n_cmp++; if (ifa.o_drive_a !== ea[31:0] || ifa.o_drive_b !== eb[31:0]) begin n_err++; $display("FAIL clean_drive[%0d] got %h/%h exp %h/%h", i, ifa.o_drive_a, ifa.o_drive_b, ea[31:0], eb[31:0]); end
        end
        ifa.enable = 0;
        @(negedge clk);
        n_cmp++; if (ifa.o_data_ctr !== 32'd100) begin n_err++; $display("FAIL clean_data got %0d exp 100", ifa.o_data_ctr); end
        n_cmp++; if (ifa.o_event_ctr !== 32'd0 || ifa.o_err_valid !== 1'b0) begin n_err++; $display("FAIL clean_event got %0d v=%b exp 0 v=0", ifa.o_event_ctr, ifa.o_err_valid); end
        n_cmp++; if (ifa.o_state !== 2'b00) begin n_err++; $display("FAIL clean_state got %b exp 00", ifa.o_state); end
    endtask

    task automatic test_fault_capture();
        logic [63:0] ea = 64'hCAFEF00D, eb = 64'hFEEDC0DE, got, fa = 0, fb = 0, fg = 0;
        int n = $urandom_range(60, 120);
        int cnt = 0;
        for (int j = 1; j <= n; j++) begin
            ea  = ref_step(ea, 64'h80200003, 32);
            eb  = ref_step(eb, 64'h80200003, 32);
            got = (ea[0] && eb[0]) ? ea : ref_op(2'd0, ea, eb, 32);
            if (got != ref_op(2'd0, ea, eb, 32)) begin
                if (cnt == 0) begin fa = ea; fb = eb; fg = got; end
                cnt++;
            end
        end
        do_reset();
        fault_a = 1; ifa.i_mode = 2'd0;
        ifa.enable = 1;
        repeat (n) @(negedge clk);
        ifa.enable = 0;
        @(negedge clk);
        n_cmp++; if (ifa.o_data_ctr !== 32'(n)) begin n_err++; $display("FAIL fault_data got %0d exp %0d", ifa.o_data_ctr, n); end
        n_cmp++; if (ifa.o_event_ctr !== 32'(cnt)) begin n_err++; $display("FAIL fault_event got %0d exp %0d", ifa.o_event_ctr, cnt); end
        n_cmp++; if (ifa.o_err_valid !== (cnt > 0)) begin n_err++; $display("FAIL fault_valid got %b exp %b", ifa.o_err_valid, cnt > 0); end
        n_cmp++; if (ifa.o_err_a !== fa[31:0] || ifa.o_err_b !== fb[31:0] || ifa.o_err_got !== fg[31:0]) begin n_err++; $display("FAIL fault_capture got %h/%h/%h exp %h/%h/%h", ifa.o_err_a, ifa.o_err_b, ifa.o_err_got, fa[31:0], fb[31:0], fg[31:0]); end
        fault_a = 0;
    endtask

    task automatic test_stop_on_err();
        logic [63:0] ea = 64'hCAFEF00D, eb = 64'hFEEDC0DE, ha = 0;
        int p = 0;
        int edges = 0;
        for (int j = 1; j <= 500 && p == 0; j++) begin
            ea = ref_step(ea, 64'h80200003, 32);
            eb = ref_step(eb, 64'h80200003, 32);
            if (ea[0] && eb[0]) begin p = j; ha = ea; end
        end
        do_reset();
        fault_a = 1; ifa.i_stop_on_err = 1; ifa.i_mode = 2'd0;
        ifa.enable = 1;
        while (ifa.o_state !== 2'b11 && edges < 600) begin
            @(negedge clk);
            edges++;
        end
        n_cmp++; if (edges !== p + 1) begin n_err++; $display("FAIL halt_edge got %0d exp %0d", edges, p + 1); end
        n_cmp++; if (ifa.o_data_ctr !== 32'(p) || ifa.o_event_ctr !== 32'd1) begin n_err++; $display("FAIL halt_ctrs got %0d/%0d exp %0d/1", ifa.o_data_ctr, ifa.o_event_ctr, p); end
        n_cmp++; if (ifa.o_drive_a !== ha[31:0] || ifa.o_err_a !== ha[31:0]) begin n_err++; $display("FAIL halt_drive got %h err_a %h exp %h", ifa.o_drive_a, ifa.o_err_a, ha[31:0]); end
        for (int i = 0; i < 8; i++) begin
            ifa.enable = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        n_cmp++; if (ifa.o_state !== 2'b11 || ifa.o_drive_a !== ha[31:0] || ifa.o_data_ctr !== 32'(p)) begin n_err++; $display("FAIL halt_sticky got st=%b a=%h d=%0d exp st=11 a=%h d=%0d", ifa.o_state, ifa.o_drive_a, ifa.o_data_ctr, ha[31:0], p); end
        fault_a = 0; ifa.i_stop_on_err = 0;
    endtask

    task automatic test_modes_lat4();
        logic [63:0] ea = 64'hF00D, eb = 64'hC0DE;
        int n = $urandom_range(30, 60);
        do_reset();
        short_b = 0;
        ifb.enable = 1;
        for (int i = 0; i < n; i++) begin
            if (i % 3 == 0) ifb.i_mode = 2'($urandom_range(0, 3));
            @(negedge clk);
            ea = ref_step(ea, 64'hB400, 16);
            eb = ref_step(eb, 64'hB400, 16);
        end
        ifb.enable = 0;
        repeat (4) @(negedge clk);
        n_cmp++; if (ifb.o_data_ctr !== 16'(n)) begin n_err++; $display("FAIL modes_data got %0d exp %0d", ifb.o_data_ctr, n); end
        n_cmp++; if (ifb.o_event_ctr !== 16'd0 || ifb.o_err_valid !== 1'b0) begin n_err++; $display("FAIL modes_event got %0d v=%b exp 0 v=0", ifb.o_event_ctr, ifb.o_err_valid); end
        n_cmp++; if (ifb.o_drive_a !== ea[15:0] || ifb.o_drive_b !== eb[15:0]) begin n_err++; $display("FAIL modes_drive got %h/%h exp %h/%h", ifb.o_drive_a, ifb.o_drive_b, ea[15:0], eb[15:0]); end
    endtask

    task automatic test_short_pipe();
        logic [63:0] sa[$], sb[$], ss[$];
        logic [63:0] ea = 64'hF00D, eb = 64'hC0DE, fa = 0, fb = 0, fg = 0, got;
        int n = $urandom_range(20, 40);
        int cnt = 0;
        for (int j = 0; j < n; j++) begin
            ea = ref_step(ea, 64'hB400, 16);
            eb = ref_step(eb, 64'hB400, 16);
            sa.push_back(ea); sb.push_back(eb); ss.push_back(ref_op(2'd0, ea, eb, 16));
        end
        // One stage short: each compare sees the next sample's result; the last sees its own.
        for (int j = 0; j < n; j++) begin
            got = (j + 1 < n) ? ss[j+1] : ss[j];
            if (got != ss[j]) begin
                if (cnt == 0) begin fa = sa[j]; fb = sb[j]; fg = got; end
                cnt++;
            end
        end
        ifb.i_mode = 2'd0;
        do_reset();
        short_b = 1;
        ifb.enable = 1;
        repeat (n) @(negedge clk);
        ifb.enable = 0;
        repeat (4) @(negedge clk);
        n_cmp++; if (ifb.o_data_ctr !== 16'(n)) begin n_err++; $display("FAIL short_data got %0d exp %0d", ifb.o_data_ctr, n); end
        n_cmp++; if (ifb.o_event_ctr !== 16'(cnt)) begin n_err++; $display("FAIL short_event got %0d exp %0d", ifb.o_event_ctr, cnt); end
        n_cmp++; if (ifb.o_err_a !== fa[15:0] || ifb.o_err_b !== fb[15:0] || ifb.o_err_got !== fg[15:0]) begin n_err++; $display("FAIL short_capture got %h/%h/%h exp %h/%h/%h", ifb.o_err_a, ifb.o_err_b, ifb.o_err_got, fa[15:0], fb[15:0], fg[15:0]); end
        short_b = 0;
    endtask

    task automatic test_freeze();
        logic [63:0] ea = 64'hCAFEF00D, eb = 64'hFEEDC0DE;
        int r1 = $urandom_range(15, 30);
        int r2 = $urandom_range(10, 20);
        do_reset();
        ifa.i_mode = 2'd0;
        ifa.enable = 1;
        for (int i = 0; i < r1; i++) begin
            @(negedge clk);
            ea = ref_step(ea, 64'h80200003, 32);
            eb = ref_step(eb, 64'h80200003, 32);
        end
        ifa.freeze = 1;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            n_cmp++; if (ifa.o_state !== 2'b10 || ifa.o_drive_a !== ea[31:0] || ifa.o_data_ctr !== 32'(r1 - 1)) begin n_err++; $display("FAIL frozen[%0d] got st=%b a=%h d=%0d exp st=10 a=%h d=%0d", i, ifa.o_state, ifa.o_drive_a, ifa.o_data_ctr, ea[31:0], r1 - 1); end
        end
        ifa.freeze = 0;
        for (int i = 0; i < r2; i++) begin
            @(negedge clk);
            ea = ref_step(ea, 64'h80200003, 32);
            eb = ref_step(eb, 64'h80200003, 32);
            n_cmp++; if (ifa.o_drive_a !== ea[31:0] || ifa.o_drive_b !== eb[31:0]) begin n_err++; $display("FAIL resume_drive[%0d] got %h/%h exp %h/%h", i, ifa.o_drive_a, ifa.o_drive_b, ea[31:0], eb[31:0]); end
        end
        ifa.enable = 0;
        @(negedge clk);
        n_cmp++; if (ifa.o_data_ctr !== 32'(r1 - 1 + r2) || ifa.o_event_ctr !== 32'd0) begin n_err++; $display("FAIL resume_ctrs got %0d/%0d exp %0d/0", ifa.o_data_ctr, ifa.o_event_ctr, r1 - 1 + r2); end
        n_cmp++; if (ifa.o_state !== 2'b00) begin n_err++; $display("FAIL resume_state got %b exp 00", ifa.o_state); end
    endtask

    task automatic test_saturate_and_async_reset();
        logic [63:0] a1, b1, g1;
        a1 = ref_step(64'h0D, 64'hB8, 8);
        b1 = ref_step(64'hDE, 64'hB8, 8);
        g1 = ~ref_op(2'd0, a1, b1, 8) & 64'hFF;
        do_reset();
        ifc.i_mode = 2'd0;
        ifc.enable = 1;
        repeat (40) @(negedge clk);
        n_cmp++; if (ifc.o_data_ctr !== 4'hF || ifc.o_event_ctr !== 4'hF) begin n_err++; $display("FAIL sat_ctrs got %0d/%0d exp 15/15", ifc.o_data_ctr, ifc.o_event_ctr); end
        n_cmp++; if (ifc.o_err_valid !== 1'b1 || ifc.o_err_a !== a1[7:0] || ifc.o_err_b !== b1[7:0] || ifc.o_err_got !== g1[7:0]) begin n_err++; $display("FAIL sat_capture got v=%b %h/%h/%h exp v=1 %h/%h/%h", ifc.o_err_valid, ifc.o_err_a, ifc.o_err_b, ifc.o_err_got, a1[7:0], b1[7:0], g1[7:0]); end
        @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_cmp++; if (ifc.o_drive_a !== 8'h0D || ifc.o_drive_b !== 8'hDE || ifc.o_state !== 2'b00) begin n_err++; $display("FAIL async_drive got %h/%h st=%b exp 0d/de st=00", ifc.o_drive_a, ifc.o_drive_b, ifc.o_state); end
        n_cmp++; if (ifc.o_data_ctr !== 4'd0 || ifc.o_event_ctr !== 4'd0 || ifc.o_err_valid !== 1'b0 || ifc.o_err_got !== 8'd0) begin n_err++; $display("FAIL async_ctrs got %0d/%0d v=%b g=%h exp 0/0 v=0 g=00", ifc.o_data_ctr, ifc.o_event_ctr, ifc.o_err_valid, ifc.o_err_got); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        n_cmp++; if (ifc.o_drive_a !== a1[7:0] || ifc.o_drive_b !== b1[7:0]) begin n_err++; $display("FAIL restart_drive got %h/%h exp %h/%h", ifc.o_drive_a, ifc.o_drive_b, a1[7:0], b1[7:0]); end
        ifc.enable = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.i_stop_on_err = 0; ifb.i_stop_on_err = 0; ifc.i_stop_on_err = 0;
        ifa.i_mode = 0; ifb.i_mode = 0; ifc.i_mode = 0;
        ifa.enable = 0; ifb.enable = 0; ifc.enable = 0;
        ifa.freeze = 0; ifb.freeze = 0; ifc.freeze = 0;
        test_reset();
        test_clean_run();
        test_fault_capture();
        test_stop_on_err();
        test_modes_lat4();
        test_short_pipe();
        test_freeze();
        test_saturate_and_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
